// File: rtl/ro_measure_ctrl_if.sv
// Result handshake between the ring-oscillator measurement controller and its consumer.
interface ro_measure_ctrl_if #(
  parameter int SEL_W = 3,
  parameter int CNT_W = 16
);
  logic             res_valid;
  logic             res_ready;
  logic [SEL_W-1:0] res_idx;
  logic [CNT_W-1:0] res_count;
  logic             res_sat;

  modport master (
    output res_valid,
    output res_idx,
    output res_count,
    output res_sat,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_idx,
    input  res_count,
    input  res_sat,
    output res_ready
  );
endinterface

// File: rtl/ro_measure_ctrl.sv
// Sweeps N_RO ring oscillators: enable, settle, count rising edges over a gate window, report.
// Optional macro RO_CMP_EN adds a pairwise count comparison response (resp_bits/resp_valid).
module ro_measure_ctrl #(
  parameter int N_RO          = 8,
  parameter int SEL_W         = 3,
  parameter int CNT_W         = 16,
  parameter int GATE_CYCLES   = 1024,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              ro_in,
  output logic [N_RO-1:0]   ro_en,
  output logic [SEL_W-1:0]  ro_sel,
  output logic              busy,
  output logic              done,
`ifdef RO_CMP_EN
  output logic [N_RO/2-1:0] resp_bits,
  output logic              resp_valid,
`endif
  ro_measure_ctrl_if.master res_if
);

  localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N_RO - 1);
  localparam logic [N_RO-1:0]  EN_ONE   = N_RO'(1);

  typedef enum logic [1:0] {IDLE, SETTLE, GATE, REPORT} state_t;

  state_t           state_q;
  logic [SEL_W-1:0] idx_q;
  logic [SEL_W-1:0] idx_nxt;
  logic [TMR_W-1:0] tmr_q;
  logic [N_RO-1:0]  ro_en_q;
  logic             busy_q;
  logic             done_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             sat_q;
  logic             sat_d;
  logic             sync1_q;
  logic             sync2_q;
  logic             sync3_q;
  logic             rise;

`ifdef RO_CMP_EN
  localparam int PW = (SEL_W > 1) ? SEL_W - 1 : 1;
  logic [CNT_W-1:0]  even_q [N_RO/2];
  logic [N_RO/2-1:0] resp_bits_q;
  logic              resp_valid_q;
  logic [PW-1:0]     pair;

  assign pair       = PW'(idx_q >> 1);
  assign resp_bits  = resp_bits_q;
  assign resp_valid = resp_valid_q;
`endif

  assign rise    = sync2_q & ~sync3_q;
  assign idx_nxt = idx_q + SEL_W'(1);

  // Saturating edge count; the flag latches once the counter reaches all-ones.
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (rise && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_MAX - CNT_W'(1)) begin
        sat_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (abort && (state_q != IDLE))) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tmr_q   <= '0;
      ro_en_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
`ifdef RO_CMP_EN
      resp_bits_q  <= '0;
      resp_valid_q <= 1'b0;
      for (int k = 0; k < N_RO/2; k++) begin
        even_q[k] <= '0;
      end
`endif
    end else begin
      done_q  <= 1'b0;
      sync1_q <= ro_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
`ifdef RO_CMP_EN
      resp_valid_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          // abort outranks a coincident start even while idle
          if (start && !abort) begin
            state_q <= SETTLE;
            idx_q   <= '0;
            tmr_q   <= TMR_W'(SETTLE_CYCLES - 1);
            ro_en_q <= EN_ONE;
            busy_q  <= 1'b1;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
`ifdef RO_CMP_EN
            resp_bits_q <= '0;
`endif
          end
        end
        SETTLE: begin
          if (tmr_q == '0) begin
            state_q <= GATE;
            tmr_q   <= TMR_W'(GATE_CYCLES - 1);
            cnt_q   <= '0;
            sat_q   <= 1'b0;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        GATE: begin
          cnt_q <= cnt_d;
          sat_q <= sat_d;
          if (tmr_q == '0) begin
            state_q <= REPORT;
            ro_en_q <= '0;
            valid_q <= 1'b1;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        REPORT: begin
          if (res_if.res_ready) begin
            valid_q <= 1'b0;
`ifdef RO_CMP_EN
            if (!idx_q[0]) begin
              even_q[pair] <= cnt_q;
            end else begin
              resp_bits_q[pair] <= (even_q[pair] > cnt_q);
            end
`endif
            if (idx_q == IDX_LAST) begin
              state_q <= IDLE;
              idx_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
`ifdef RO_CMP_EN
              resp_valid_q <= 1'b1;
`endif
            end else begin
              // fresh synchronizer so the previous oscillator's level cannot fake an edge
              state_q <= SETTLE;
              idx_q   <= idx_nxt;
              tmr_q   <= TMR_W'(SETTLE_CYCLES - 1);
              ro_en_q <= EN_ONE << idx_nxt;
              sync1_q <= 1'b0;
              sync2_q <= 1'b0;
              sync3_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ro_en            = ro_en_q;
  assign ro_sel           = idx_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign res_if.res_valid = valid_q;
  assign res_if.res_idx   = idx_q;
  assign res_if.res_count = cnt_q;
  assign res_if.res_sat   = sat_q;

endmodule

// File: doc/ro_measure_ctrl.md
Name: ro_measure_ctrl

Overview:
- Sequences a bank of N_RO ring oscillators built from the team's inverter cells.
- Enables one oscillator at a time, waits a settle interval, counts its rising edges over a fixed gate window in the clk domain, then reports the count through a valid/ready handshake.
- Sits between the ring-oscillator array (enable lines, output mux) and the readout/PUF logic.

Parameters:
- N_RO, 8, number of ring oscillators (power of 2, >=2)
- SEL_W, 3, width of mux select / index (log2 N_RO)
- CNT_W, 16, edge-counter width
- GATE_CYCLES, 1024, gate window length in clk cycles (>=1)
- SETTLE_CYCLES, 16, cycles between RO enable and gate open (>=1)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- start  input  1  one-cycle pulse; begins a sweep of all N_RO oscillators
- abort  input  1  terminates the sweep in progress
- ro_in  input  1  selected oscillator output (asynchronous to clk, pre-divided to < clk/4)
- ro_en  output  N_RO  one-hot oscillator enable
- ro_sel  output  SEL_W  output-mux select, equals current index
- busy  output  1  high from the cycle after an accepted start until return to IDLE
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_idx  output  SEL_W  oscillator index of the result
- res_count  output  CNT_W  rising-edge count in gate window
- res_sat  output  1  count saturated
- done  output  1  one-cycle pulse after last result is accepted

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: ro_en=0, ro_sel=0, busy=0, res_valid=0, res_idx=0, res_count=0, res_sat=0, done=0. State=IDLE, all counters and synchronizer flops cleared.
- ro_in path: 2-flop synchronizer, then a third flop; rising edge = sync2 & ~sync3. Synchronizer flops clear on every SETTLE entry.
- FSM states: IDLE, SETTLE, GATE, REPORT.
- IDLE:
  - start=1 -> SETTLE next cycle with idx=0 and busy=1.
  - start is ignored in every other state.
- SETTLE:
  - ro_en = 1<<idx; ro_sel = idx.
  - Stays exactly SETTLE_CYCLES cycles, then -> GATE.
  - Edge counter cleared to 0 on the SETTLE->GATE transition.
- GATE:
  - ro_en held.
  - Each detected edge increments the count.
  - At 2^CNT_W-1 the count holds and res_sat is set.
  - Lasts exactly GATE_CYCLES cycles, then -> REPORT.
- REPORT:
  - ro_en=0.
  - res_valid=1; res_idx, res_count and res_sat are stable until the handshake.
  - Handshake completes in the cycle where res_valid & res_ready; res_valid drops the next cycle.
  - After the handshake: if idx==N_RO-1 -> IDLE, busy=0, done=1 for one cycle. Otherwise idx+1 -> SETTLE.
  - res_ready held high gives back-to-back measurements with zero stall.
- abort (any non-IDLE state): next cycle IDLE, all outputs at reset values, no done pulse, no partial result.
- rst has priority over abort, and abort has priority over start.
- rst mid-sweep behaves identically to abort.
- Latency per oscillator: SETTLE_CYCLES + GATE_CYCLES + 1 cycles minimum.
- Full sweep latency: N_RO times the per-oscillator figure, plus 1 cycle.

Optional Feature:
- Macro RO_CMP_EN.
- When defined:
  - Adds output resp_bits[N_RO/2-1:0] and output resp_valid.
  - Stores each even-index count.
  - On the odd-index handshake, bit k = (count[2k] > count[2k+1]). A tie gives 0.
  - resp_valid pulses with done; resp_bits hold until the next start.
  - resp_bits reset to 0; abort clears them.
- When undefined: no storage, no extra ports; behaviour otherwise identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> every output 0, busy stays 0 for 20 cycles with start=0.
- Basic sweep (N_RO=4, SETTLE=4, GATE=100, res_ready=1, ro_in period 10 clk) -> 4 results, res_idx 0..3, res_count 10 (+-1), ro_en 0001/0010/0100/1000 in order, done one cycle after the 4th handshake.
- Backpressure: res_ready=0 for 50 cycles in REPORT -> res_valid and data stable, ro_en=0, no idx advance; res_ready=1 -> idx advances next cycle.
- Saturation (CNT_W=4, GATE=100, ro_in period 4) -> res_count=15, res_sat=1.
- Abort in GATE of idx 2 -> next cycle IDLE, busy=0, no done; a new start restarts at idx 0 with count 0.
- RO_CMP_EN (N_RO=4): periods 10/20/20/10 -> resp_bits=2'b01, resp_valid coincides with done.
